// File: rtl/wb_exc_commit_if.sv
// wb_exc_commit_if: bundle of the MEM->WB handshake, CSR-file commit bus and
// front-end redirect handshake used by wb_exc_commit.
//   slave  : the commit unit (consumes MEM/CSR/ack, drives commit/flush outputs)
//   master : the surrounding pipeline / testbench
interface wb_exc_commit_if;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic [31:0] ms_vaddr;
  logic [5:0]  ms_exc;        // {ale,brk,sys,ine,adem,adef}
  logic        ms_ertn;
  logic        has_int;
  logic [31:0] csr_eentry;
  logic [31:0] csr_era;
  logic        ws_valid;
  logic        ws_rf_kill;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic        eret_flush;
  logic        flush_req;
  logic [31:0] flush_target;
  logic        redirect_ack;

  modport slave (
    input  ms_to_ws_valid, ms_pc, ms_vaddr, ms_exc, ms_ertn, has_int,
           csr_eentry, csr_era, redirect_ack,
    output ws_allowin, ws_valid, ws_rf_kill, wb_ex, wb_ecode, wb_esubcode,
           wb_pc, wb_vaddr, eret_flush, flush_req, flush_target
  );

  modport master (
    output ms_to_ws_valid, ms_pc, ms_vaddr, ms_exc, ms_ertn, has_int,
           csr_eentry, csr_era, redirect_ack,
    input  ws_allowin, ws_valid, ws_rf_kill, wb_ex, wb_ecode, wb_esubcode,
           wb_pc, wb_vaddr, eret_flush, flush_req, flush_target
  );
endinterface

// File: rtl/wb_exc_commit.sv
// wb_exc_commit: writeback-stage exception / ERTN commit unit feeding the CSR file.
// Latches the instruction leaving MEM, tags a pending interrupt at entry,
// priority-encodes exception flags, emits one-cycle wb_ex / eret_flush pulses
// and holds flush_req with the redirect target until the front end acks.
// Ports:
//   clk, resetn         clock, asynchronous active-low reset
//   bus (slave)         MEM handshake, CSR inputs, commit outputs, redirect handshake
//   exc_count           exception statistics counter (only with WB_EXC_STATS_EN)
// Optional feature macro: WB_EXC_STATS_EN (adds exc_count port and counter).
//
// state   | meaning
// S_IDLE  | WB accepts from MEM; commits exceptions / ERTN
// S_FLUSH | flush_req high, MEM input discarded, waiting for min time + ack
module wb_exc_commit #(
  parameter int FLUSH_MIN_CYCLES = 1,
  parameter int CNT_W            = 16
) (
  input  logic             clk,
  input  logic             resetn,
  wb_exc_commit_if.slave   bus
`ifdef WB_EXC_STATS_EN
  ,
  output logic [CNT_W-1:0] exc_count
`endif
);

  localparam int CW = $clog2(FLUSH_MIN_CYCLES + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_MIN_CYCLES);

  typedef enum logic {S_IDLE, S_FLUSH} state_e;

  state_e         state_q, state_d;
  logic           ws_valid_q, ws_valid_d;
  logic [31:0]    pc_q, pc_d;
  logic [31:0]    vaddr_q, vaddr_d;
  logic [5:0]     exc_q, exc_d;
  logic           ertn_q, ertn_d;
  logic           int_tag_q, int_tag_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ack_q, ack_d;
  logic [31:0]    target_q, target_d;

  logic idle, ws_ready_go, allowin, transfer;
  logic ex_any, commit_ex, commit_ertn, ack_seen;
  logic [5:0] ecode;
  logic [8:0] esubcode;

  assign ws_ready_go = 1'b1;

  always_comb begin
    idle        = (state_q == S_IDLE);
    allowin     = idle & (~ws_valid_q | ws_ready_go);
    transfer    = bus.ms_to_ws_valid & allowin;
    ex_any      = ws_valid_q & (int_tag_q | (|exc_q));
    commit_ex   = ex_any & idle;
    commit_ertn = ws_valid_q & ertn_q & ~ex_any & idle;
    // an ack seen earlier in the flush still counts once the minimum time is met
    ack_seen    = bus.redirect_ack | ack_q;

    state_d    = state_q;
    ws_valid_d = ws_valid_q;
    pc_d       = pc_q;
    vaddr_d    = vaddr_q;
    exc_d      = exc_q;
    ertn_d     = ertn_q;
    int_tag_d  = int_tag_q;
    cnt_d      = cnt_q;
    ack_d      = ack_q;
    target_d   = target_q;

    if (transfer) begin
      pc_d      = bus.ms_pc;
      vaddr_d   = bus.ms_vaddr;
      exc_d     = bus.ms_exc;
      ertn_d    = bus.ms_ertn;
      int_tag_d = bus.has_int;
    end

    case (state_q)
      S_IDLE: begin
        if (commit_ex || commit_ertn) begin
          // the younger instruction transferring at this edge is killed too
          state_d    = S_FLUSH;
          ws_valid_d = 1'b0;
          target_d   = commit_ex ? bus.csr_eentry : bus.csr_era;
          cnt_d      = CNT_INIT;
          ack_d      = 1'b0;
        end else begin
          ws_valid_d = bus.ms_to_ws_valid;
        end
      end
      S_FLUSH: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        if (ack_seen && (cnt_q <= CW'(1))) begin
          state_d = S_IDLE;
          ack_d   = 1'b0;
        end else begin
          ack_d = ack_seen;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ecode    = 6'h00;
    esubcode = 9'h000;
    if (ex_any) begin
      if (int_tag_q)     begin ecode = 6'h00; esubcode = 9'h000; end
      else if (exc_q[0]) begin ecode = 6'h08; esubcode = 9'h000; end
      else if (exc_q[2]) begin ecode = 6'h0D; esubcode = 9'h000; end
      else if (exc_q[3]) begin ecode = 6'h0B; esubcode = 9'h000; end
      else if (exc_q[4]) begin ecode = 6'h0C; esubcode = 9'h000; end
      else if (exc_q[1]) begin ecode = 6'h08; esubcode = 9'h001; end
      else               begin ecode = 6'h09; esubcode = 9'h000; end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      ws_valid_q <= 1'b0;
      pc_q       <= '0;
      vaddr_q    <= '0;
      exc_q      <= '0;
      ertn_q     <= 1'b0;
      int_tag_q  <= 1'b0;
      cnt_q      <= '0;
      ack_q      <= 1'b0;
      target_q   <= '0;
    end else begin
      state_q    <= state_d;
      ws_valid_q <= ws_valid_d;
      pc_q       <= pc_d;
      vaddr_q    <= vaddr_d;
      exc_q      <= exc_d;
      ertn_q     <= ertn_d;
      int_tag_q  <= int_tag_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      target_q   <= target_d;
    end
  end

  assign bus.ws_allowin   = allowin;
  assign bus.ws_valid     = ws_valid_q;
  assign bus.ws_rf_kill   = ex_any;
  assign bus.wb_ex        = commit_ex;
  assign bus.wb_ecode     = ecode;
  assign bus.wb_esubcode  = esubcode;
  assign bus.wb_pc        = pc_q;
  assign bus.wb_vaddr     = vaddr_q;
  assign bus.eret_flush   = commit_ertn;
  assign bus.flush_req    = ~idle;
  assign bus.flush_target = target_q;

`ifdef WB_EXC_STATS_EN
  logic [CNT_W-1:0] exc_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                      exc_cnt_q <= '0;
    else if (commit_ex && ~&exc_cnt_q) exc_cnt_q <= exc_cnt_q + CNT_W'(1);
  end

  assign exc_count = exc_cnt_q;
`endif

endmodule

// File: tb/tb_wb_exc_commit.sv
module tb_wb_exc_commit;
  localparam int MINC = 3;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  wb_exc_commit_if bus();
`ifdef WB_EXC_STATS_EN
  logic [15:0] exc_count;
`endif

  wb_exc_commit #(.FLUSH_MIN_CYCLES(MINC), .CNT_W(16)) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
`ifdef WB_EXC_STATS_EN
    ,
    .exc_count(exc_count)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // reference model: WB slot contents plus flush bookkeeping by elapsed cycles
  bit          m_v, m_ertn, m_itag, m_flush, m_ack;
  logic [31:0] m_pc, m_va, m_tgt;
  logic [5:0]  m_exc;
  int          m_fc, m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_v = 0; m_ertn = 0; m_itag = 0; m_flush = 0; m_ack = 0;
    m_pc = '0; m_va = '0; m_tgt = '0; m_exc = '0; m_fc = 0; m_cnt = 0;
  endfunction

  // priority list, highest first: adef, ine, sys, brk, adem, ale
  function automatic void exp_code(output logic [5:0] ec, output logic [8:0] es);
    int          order[6] = '{0, 2, 3, 4, 1, 5};
    logic [5:0]  codes[6] = '{6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h08, 6'h09};
    ec = 6'h00; es = 9'h000;
    if (m_itag) return;
    for (int i = 0; i < 6; i++) begin
      if (m_exc[order[i]]) begin
        ec = codes[i];
        es = (order[i] == 1) ? 9'h001 : 9'h000;
        return;
      end
    end
  endfunction

  task automatic check();
    bit ex, er;
    logic [5:0] ec;
    logic [8:0] es;
    ex = m_v && (m_itag || m_exc != 6'h00);
    er = m_v && m_ertn && !ex;
    chk("ws_valid",     bus.ws_valid,     m_v);
    chk("ws_allowin",   bus.ws_allowin,   !m_flush);
    chk("flush_req",    bus.flush_req,    m_flush);
    chk("flush_target", bus.flush_target, m_tgt);
    chk("wb_ex",        bus.wb_ex,        ex && !m_flush);
    chk("eret_flush",   bus.eret_flush,   er && !m_flush);
    chk("ws_rf_kill",   bus.ws_rf_kill,   ex);
    if (ex) begin
      exp_code(ec, es);
      chk("wb_ecode",    bus.wb_ecode,    ec);
      chk("wb_esubcode", bus.wb_esubcode, es);
    end
    if (m_v) begin
      chk("wb_pc",    bus.wb_pc,    m_pc);
      chk("wb_vaddr", bus.wb_vaddr, m_va);
    end
`ifdef WB_EXC_STATS_EN
    chk("exc_count", exc_count, m_cnt);
`endif
  endtask

  task automatic tick();
    bit ex, er;
    ex = m_v && (m_itag || m_exc != 6'h00);
    er = m_v && m_ertn && !ex;
    if (!m_flush) begin
      if (ex || er) begin
        m_flush = 1; m_fc = 0; m_ack = 0; m_v = 0;
        m_tgt = ex ? bus.csr_eentry : bus.csr_era;
        if (ex && m_cnt < 65535) m_cnt++;
      end else begin
        m_v = bus.ms_to_ws_valid;
        if (m_v) begin
          m_pc = bus.ms_pc; m_va = bus.ms_vaddr; m_exc = bus.ms_exc;
          m_ertn = bus.ms_ertn; m_itag = bus.has_int;
        end
      end
    end else begin
      // flush lasts max(MINC, cycle of first ack) cycles
      m_fc++;
      if (bus.redirect_ack) m_ack = 1;
      if (m_ack && m_fc >= MINC) m_flush = 0;
    end
    @(posedge clk);
    #1;
    check();
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] va,
                       input logic [5:0] exc, input bit ertn);
    bus.ms_to_ws_valid = v;
    bus.ms_pc          = pc;
    bus.ms_vaddr       = va;
    bus.ms_exc         = exc;
    bus.ms_ertn        = ertn;
  endtask

  // from a commit cycle: step into the flush, hold ack, count flush_req cycles
  task automatic drain(output int n);
    tick();
    n = 0;
    bus.redirect_ack = 1'b1;
    while (bus.flush_req && n < 20) begin
      n++;
      tick();
    end
    bus.redirect_ack = 1'b0;
  endtask

  int n;

  initial begin
    resetn = 1'b0;
    drive(0, '0, '0, '0, 0);
    bus.has_int = 1'b0;
    bus.redirect_ack = 1'b0;
    bus.csr_eentry = 32'h1C008000;
    bus.csr_era = 32'h1C000204;
    model_reset();
    #22;
    check();
    chk("rst_wb_pc", bus.wb_pc, 32'h0);
    chk("rst_ecode", bus.wb_ecode, 6'h00);
    chk("rst_allowin", bus.ws_allowin, 1'b1);
    resetn = 1'b1;
    tick();

    // SYS
    drive(1, 32'h1C000100, 32'h0, 6'b001000, 0);
    tick();
    chk("sys_wb_ex", bus.wb_ex, 1'b1);
    chk("sys_ecode", bus.wb_ecode, 6'h0B);
    chk("sys_pc", bus.wb_pc, 32'h1C000100);
    drive(0, '0, '0, '0, 0);
    drain(n);
    chk("sys_target", bus.flush_target, 32'h1C008000);

    // adef + ale
    drive(1, 32'h80000003, 32'h00001234, 6'b100001, 0);
    tick();
    chk("adef_ecode", bus.wb_ecode, 6'h08);
    chk("adef_esub", bus.wb_esubcode, 9'h000);
    chk("adef_kill", bus.ws_rf_kill, 1'b1);
    drive(0, '0, '0, '0, 0);
    drain(n);

    // ale
    drive(1, 32'h1C000110, 32'h00001002, 6'b100000, 0);
    tick();
    chk("ale_ecode", bus.wb_ecode, 6'h09);
    chk("ale_vaddr", bus.wb_vaddr, 32'h00001002);
    drive(0, '0, '0, '0, 0);
    drain(n);

    // adem alone
    drive(1, 32'h1C000114, 32'h00000FF0, 6'b000010, 0);
    tick();
    chk("adem_ecode", bus.wb_ecode, 6'h08);
    chk("adem_esub", bus.wb_esubcode, 9'h001);
    drive(0, '0, '0, '0, 0);
    drain(n);

    // ERTN
    drive(1, 32'h1C000120, 32'h0, 6'b000000, 1);
    tick();
    chk("ertn_pulse", bus.eret_flush, 1'b1);
    chk("ertn_no_ex", bus.wb_ex, 1'b0);
    drive(0, '0, '0, '0, 0);
    drain(n);
    chk("ertn_target", bus.flush_target, 32'h1C000204);

    // ERTN + ine: exception wins
    drive(1, 32'h1C000124, 32'h0, 6'b000100, 1);
    tick();
    chk("ertn_ine_ex", bus.wb_ex, 1'b1);
    chk("ertn_ine_ecode", bus.wb_ecode, 6'h0D);
    chk("ertn_ine_noeret", bus.eret_flush, 1'b0);
    drive(0, '0, '0, '0, 0);
    drain(n);

    // minimum flush length with ack held from cycle 1; MEM traffic dropped
    drive(1, 32'h1C000130, 32'h0, 6'b001000, 0);
    tick();
    drive(1, 32'h1C000134, 32'h0, 6'b000000, 0);
    drain(n);
    chk("flush_len", n, MINC);
    chk("flush_dropped", bus.ws_valid, 1'b0);
    drive(0, '0, '0, '0, 0);
    tick();

    // ack pulse only in flush cycle 1 is remembered
    drive(1, 32'h1C000140, 32'h0, 6'b010000, 0);
    tick();
    drive(0, '0, '0, '0, 0);
    tick();
    bus.redirect_ack = 1'b1;
    tick();
    bus.redirect_ack = 1'b0;
    tick();
    tick();
    chk("sticky_ack_exit", bus.flush_req, 1'b0);

    // interrupt arriving mid-stage is not tagged on the resident instruction
    drive(1, 32'h1C000150, 32'h0, 6'b000000, 0);
    tick();
    bus.has_int = 1'b1;
    drive(1, 32'h1C000154, 32'h0, 6'b000000, 0);
    chk("int_not_mid", bus.wb_ex, 1'b0);
    tick();
    chk("int_next_ex", bus.wb_ex, 1'b1);
    chk("int_next_ecode", bus.wb_ecode, 6'h00);
    bus.has_int = 1'b0;
    drive(0, '0, '0, '0, 0);
    drain(n);

    // reset in the middle of a flush
    drive(1, 32'h1C000160, 32'h0, 6'b001000, 0);
    tick();
    drive(0, '0, '0, '0, 0);
    tick();
    chk("pre_rst_flush", bus.flush_req, 1'b1);
    #3;
    resetn = 1'b0;
    #1;
    model_reset();
    chk("rst_mid_flush", bus.flush_req, 1'b0);
    chk("rst_mid_allowin", bus.ws_allowin, 1'b1);
    chk("rst_mid_valid", bus.ws_valid, 1'b0);
    #2;
    resetn = 1'b1;
    tick();

    // three exceptions after reset
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h1C000200 + 32'(i * 4), 32'h0, 6'b001000, 0);
      tick();
      drive(0, '0, '0, '0, 0);
      drain(n);
    end
`ifdef WB_EXC_STATS_EN
    chk("exc_count_3", exc_count, 16'd3);
`endif

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 1) == 1, $urandom, $urandom,
            ($urandom_range(0, 3) == 0) ? (6'($urandom) & 6'($urandom)) : 6'h00,
            $urandom_range(0, 5) == 0);
      bus.has_int      = ($urandom_range(0, 9) == 0);
      bus.redirect_ack = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) bus.csr_eentry = $urandom;
      if ($urandom_range(0, 7) == 0) bus.csr_era = $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
